// File: rtl/hist_stat_sat.sv
// Ping-pong saturating histogram engine with internal bank clearing and frame-end swap.
// Optional per-frame accepted-pixel total is enabled by defining HIST_TOTAL_EN.
module hist_stat_sat #(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_BITS  = 24,
   parameter int TOTAL_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_BITS-1:0]  in_addr,
   input  logic                  in_frame_end,
   output logic                  frame_done,
   output logic                  frame_drop,
   input  logic                  out_en,
   input  logic [ADDR_BITS-1:0]  out_addr,
   output logic [DATA_BITS-1:0]  out_data,
   output logic [TOTAL_BITS-1:0] out_total
);

   localparam int NB = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {INIT, COUNT, DRAIN, CLEAR} state_t;

   state_t                state_q, state_d;
   logic                  cur_bank_q, cur_bank_d;
   logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
   logic                  drain_cnt_q, drain_cnt_d;
   logic                  frame_done_q, frame_done_d;
   logic                  frame_drop_q, frame_drop_d;
   logic                  drain_exit;
   logic                  accept;

   logic                  p1_valid_q, p1_valid_d;
   logic [ADDR_BITS-1:0]  p1_addr_q, p1_addr_d;
   logic                  w1_valid_q, w1_valid_d;
   logic [ADDR_BITS-1:0]  w1_addr_q, w1_addr_d;
   logic [DATA_BITS-1:0]  w1_data_q, w1_data_d;
   logic                  w2_valid_q, w2_valid_d;
   logic [ADDR_BITS-1:0]  w2_addr_q, w2_addr_d;
   logic [DATA_BITS-1:0]  w2_data_q, w2_data_d;
   logic [DATA_BITS-1:0]  fwd_data;

   logic [DATA_BITS-1:0]  mem0 [NB];
   logic [DATA_BITS-1:0]  mem1 [NB];
   logic [DATA_BITS-1:0]  cnt_rdata_q;
   logic [DATA_BITS-1:0]  ro_word;
   logic [DATA_BITS-1:0]  out_data_q, out_data_d;
   logic                  we0, we1;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [DATA_BITS-1:0]  wr_data;

   assign in_ready   = (state_q == COUNT);
   assign accept     = in_valid & in_ready;
   assign frame_done = frame_done_q;
   assign frame_drop = frame_drop_q;
   assign out_data   = out_data_q;

   always_comb begin
      state_d      = state_q;
      cur_bank_d   = cur_bank_q;
      clr_addr_d   = '0;
      drain_cnt_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_drop_d = 1'b0;
      drain_exit   = 1'b0;
      case (state_q)
         INIT: begin
            clr_addr_d = clr_addr_q + ADDR_BITS'(1);
            if (clr_addr_q == '1) state_d = COUNT;
         end
         COUNT: begin
            if (in_frame_end) state_d = DRAIN;
         end
         DRAIN: begin
            drain_cnt_d = 1'b1;
            if (drain_cnt_q) begin
               drain_cnt_d  = 1'b0;
               drain_exit   = 1'b1;
               cur_bank_d   = ~cur_bank_q;
               frame_done_d = 1'b1;
               state_d      = CLEAR;
            end
         end
         CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_BITS'(1);
            if (clr_addr_q == '1) state_d = COUNT;
         end
         default: state_d = INIT;
      endcase
      if (in_frame_end && (state_q != COUNT)) frame_drop_d = 1'b1;
   end

   // RAM reads are read-first, so a write landing on the same edge as a read
   // is invisible to it; the w1/w2 registers cover the two in-flight writes.
   always_comb begin
      fwd_data = cnt_rdata_q;
      if (w1_valid_q && (w1_addr_q == p1_addr_q))
         fwd_data = w1_data_q;
      else if (w2_valid_q && (w2_addr_q == p1_addr_q))
         fwd_data = w2_data_q;
      p1_valid_d = accept;
      p1_addr_d  = in_addr;
      w1_valid_d = p1_valid_q;
      w1_addr_d  = p1_addr_q;
      w1_data_d  = (fwd_data == '1) ? fwd_data : fwd_data + DATA_BITS'(1);
      w2_valid_d = w1_valid_q;
      w2_addr_d  = w1_addr_q;
      w2_data_d  = w1_data_q;
   end

   always_comb begin
      we0     = 1'b0;
      we1     = 1'b0;
      wr_addr = w1_addr_q;
      wr_data = w1_data_q;
      case (state_q)
         INIT: begin
            we0     = 1'b1;
            we1     = 1'b1;
            wr_addr = clr_addr_q;
            wr_data = '0;
         end
         CLEAR: begin
            we0     = ~cur_bank_q;
            we1     = cur_bank_q;
            wr_addr = clr_addr_q;
            wr_data = '0;
         end
         default: begin
            we0 = w1_valid_q & ~cur_bank_q;
            we1 = w1_valid_q & cur_bank_q;
         end
      endcase
      ro_word    = cur_bank_q ? mem0[out_addr] : mem1[out_addr];
      out_data_d = out_en ? ro_word : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (we0) mem0[wr_addr] <= wr_data;
      if (we1) mem1[wr_addr] <= wr_data;
      if (accept) cnt_rdata_q <= cur_bank_q ? mem1[in_addr] : mem0[in_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         cur_bank_q   <= 1'b0;
         clr_addr_q   <= '0;
         drain_cnt_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_drop_q <= 1'b0;
         p1_valid_q   <= 1'b0;
         p1_addr_q    <= '0;
         w1_valid_q   <= 1'b0;
         w1_addr_q    <= '0;
         w1_data_q    <= '0;
         w2_valid_q   <= 1'b0;
         w2_addr_q    <= '0;
         w2_data_q    <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_bank_q   <= cur_bank_d;
         clr_addr_q   <= clr_addr_d;
         drain_cnt_q  <= drain_cnt_d;
         frame_done_q <= frame_done_d;
         frame_drop_q <= frame_drop_d;
         p1_valid_q   <= p1_valid_d;
         p1_addr_q    <= p1_addr_d;
         w1_valid_q   <= w1_valid_d;
         w1_addr_q    <= w1_addr_d;
         w1_data_q    <= w1_data_d;
         w2_valid_q   <= w2_valid_d;
         w2_addr_q    <= w2_addr_d;
         w2_data_q    <= w2_data_d;
         out_data_q   <= out_data_d;
      end
   end

`ifdef HIST_TOTAL_EN
   logic [TOTAL_BITS-1:0] total_q, total_d;
   logic [TOTAL_BITS-1:0] out_total_q, out_total_d;

   always_comb begin
      total_d     = total_q;
      out_total_d = out_total_q;
      if (drain_exit) begin
         out_total_d = total_q;
         total_d     = '0;
      end else if (accept && (total_q != '1)) begin
         total_d = total_q + TOTAL_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q     <= '0;
         out_total_q <= '0;
      end else begin
         total_q     <= total_d;
         out_total_q <= out_total_d;
      end
   end

   assign out_total = out_total_q;
`else
   assign out_total = '0;
`endif

endmodule

// File: tb/tb_hist_stat_sat.sv
// Scoreboard bench for hist_stat_sat with a 16-bin, 4-bit configuration.
// out_total expectations follow whether HIST_TOTAL_EN is defined.
module tb_hist_stat_sat;

   localparam int AB = 4;
   localparam int DB = 4;
   localparam int TW = 32;
   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AB-1:0] in_addr = '0;
   logic          in_frame_end = 1'b0;
   logic          frame_done;
   logic          frame_drop;
   logic          out_en = 1'b0;
   logic [AB-1:0] out_addr = '0;
   logic [DB-1:0] out_data;
   logic [TW-1:0] out_total;

   int checks = 0;
   int errors = 0;
   int cur_hist [NB];
   int ro_hist  [NB];
   int cur_total = 0;
   int ro_total  = 0;
   logic [DB-1:0] exp_q [$];

   hist_stat_sat #(.ADDR_BITS(AB), .DATA_BITS(DB), .TOTAL_BITS(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_frame_end(in_frame_end), .frame_done(frame_done), .frame_drop(frame_drop),
      .out_en(out_en), .out_addr(out_addr), .out_data(out_data), .out_total(out_total)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear_all;
      for (int i = 0; i < NB; i++) begin
         cur_hist[i] = 0;
         ro_hist[i]  = 0;
      end
      cur_total = 0;
      ro_total  = 0;
   endtask

   task automatic model_sample(input int a);
      if (cur_hist[a] < 15) cur_hist[a]++;
      cur_total++;
   endtask

   task automatic model_swap;
      for (int i = 0; i < NB; i++) begin
         ro_hist[i]  = cur_hist[i];
         cur_hist[i] = 0;
      end
      ro_total  = cur_total;
      cur_total = 0;
   endtask

   task automatic do_reset(input string name);
      int ready_at;
      in_valid = 1'b0;
      in_frame_end = 1'b0;
      out_en = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_data !== '0 || frame_done !== 1'b0 || frame_drop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s async_reset: ready=%b data=%0d done=%b drop=%b, required 0 0 0 0",
                  name, in_ready, out_data, frame_done, frame_drop);
      end
      repeat (2) tick;
      rst = 1'b0;
      model_clear_all;
      ready_at = 0;
      for (int n = 1; n <= 40; n++) begin
         tick;
         if (in_ready === 1'b1) begin
            ready_at = n;
            break;
         end
      end
      checks++;
      if (ready_at != 16) begin
         errors++;
         $display("[TB] FAIL %s init_ready: ready after %0d edges, required 16", name, ready_at);
      end
   endtask

   task automatic read_all(input string name);
      logic [DB-1:0] exp;
      logic [TW-1:0] exp_total;
      exp = '0;
      for (int a = 0; a < NB; a++) begin
         out_en = 1'b1;
         out_addr = AB'(a);
         exp_q.push_back(DB'(ro_hist[a]));
         tick;
         exp = exp_q.pop_front();
         checks++;
         if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL %s bin%0d: got %0d, required %0d", name, a, out_data, exp);
         end
      end
      out_en = 1'b0;
      out_addr = '0;
      tick;
      checks++;
      if (out_data !== exp) begin
         errors++;
         $display("[TB] FAIL %s hold: got %0d, required %0d", name, out_data, exp);
      end
`ifdef HIST_TOTAL_EN
      exp_total = TW'(ro_total);
`else
      exp_total = '0;
`endif
      checks++;
      if (out_total !== exp_total) begin
         errors++;
         $display("[TB] FAIL %s out_total: got %0d, required %0d", name, out_total, exp_total);
      end
   endtask

   task automatic send_one(input int a, input string name);
      in_valid = 1'b1;
      in_addr = AB'(a);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s in_ready: got %b, required 1", name, in_ready);
      end
      if (in_ready === 1'b1) model_sample(a);
      tick;
      in_valid = 1'b0;
   endtask

   // drop_at > 0 pulses in_frame_end again on that edge after the closing one.
   task automatic close_frame(input bit with_sample, input int a, input int drop_at, input string name);
      int ready_at;
      in_frame_end = 1'b1;
      in_valid = with_sample;
      in_addr = AB'(a);
      if (with_sample && in_ready === 1'b1) model_sample(a);
      tick;
      in_frame_end = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s drain_entry: ready=%b done=%b, required 0 0", name, in_ready, frame_done);
      end
      ready_at = 0;
      for (int n = 1; n <= 40; n++) begin
         in_frame_end = (n == drop_at);
         tick;
         in_frame_end = 1'b0;
         checks++;
         if (frame_done !== (n == 2)) begin
            errors++;
            $display("[TB] FAIL %s frame_done edge%0d: got %b, required %b", name, n, frame_done, (n == 2));
         end
         checks++;
         if (frame_drop !== (n == drop_at)) begin
            errors++;
            $display("[TB] FAIL %s frame_drop edge%0d: got %b, required %b", name, n, frame_drop, (n == drop_at));
         end
         if (n == 2) model_swap;
         if (in_ready === 1'b1) begin
            ready_at = n;
            break;
         end
      end
      checks++;
      if (ready_at != 18) begin
         errors++;
         $display("[TB] FAIL %s turnaround: ready after %0d edges, required 18", name, ready_at);
      end
   endtask

   task automatic test_reset;
      do_reset("reset");
      read_all("reset_read");
   endtask

   task automatic test_back_to_back;
      send_one(3, "b2b");
      send_one(3, "b2b");
      send_one(3, "b2b");
      send_one(5, "b2b");
      close_frame(1'b0, 0, 0, "b2b");
      read_all("b2b_read");
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 20; i++) send_one(7, "sat");
      close_frame(1'b0, 0, 0, "sat");
      read_all("sat_read");
   endtask

   task automatic test_drop_in_clear;
      send_one(1, "drop");
      send_one(2, "drop");
      send_one(2, "drop");
      close_frame(1'b0, 0, 5, "drop_clear");
      read_all("drop_read");
      send_one(4, "drop");
      read_all("drop_midframe_read");
   endtask

   task automatic test_end_with_sample;
      close_frame(1'b1, 9, 0, "end_sample");
      read_all("end_sample_read");
      send_one(9, "next_frame");
      close_frame(1'b0, 0, 1, "drop_drain");
      read_all("next_frame_read");
   endtask

   task automatic test_forwarding;
      int pat [7] = '{6, 6, 8, 6, 8, 8, 6};
      foreach (pat[i]) send_one(pat[i], "fwd_pat");
      for (int i = 0; i < 40; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_addr = AB'($urandom_range(0, 5));
         if (in_valid && in_ready === 1'b1) model_sample(int'(in_addr));
         tick;
      end
      in_valid = 1'b0;
      close_frame(1'b0, 0, 0, "fwd");
      read_all("fwd_read");
   endtask

   task automatic test_reset_mid_frame;
      send_one(2, "mid");
      send_one(2, "mid");
      do_reset("mid_reset");
      read_all("mid_reset_read");
   endtask

   initial begin
      #1;
      test_reset;
      test_back_to_back;
      test_saturation;
      test_drop_in_clear;
      test_end_with_sample;
      test_forwarding;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, required completion before 1000000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
